mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares the single-port 32x8 memory (`read`/`write`/`addr`/`data_in`/`data_out` pin set) between NREQ requesters. Each requester issues one read or write per request/acknowledge handshake. The arbiter latches the winning command, sequences the memory strobes, captures read data, and pulses `ack` to the owner. It sits between the requester agents (DMA, CPU stub, testbench drivers) and the memory's `mem` side.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 5, address width
- DW, 8, data width
- clk  input  1  system clock; all flops rise-edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request; held high until `ack`
- we  input  NREQ  per-requester 1=write, 0=read; stable while `req`
- req_addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  input  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- ack  output  NREQ  one-cycle completion pulse to owner (one-hot or zero)
- rdata  output  DW  last read data; valid when `ack` pulses for a read, held until the next read completes
- busy  output  1  high in every state except IDLE
- mem_read  output  1  to memory `read`
- mem_write  output  1  to memory `write`
- mem_addr  output  AW  to memory `addr`
- mem_wdata  output  DW  to memory `data_in`
- mem_rdata  input  DW  from memory `data_out`; valid the cycle after `mem_read` is high

## Operation
- FSM states: IDLE, WR, RD, RCAP, DONE.
- IDLE: if any `req` is set, pick the winner with rr_picker. Latch owner, `we`, addr and wdata into command registers. Go to WR if `we`, else RD. If no `req`, stay in IDLE.
- WR: `mem_write`=1, with `mem_addr`/`mem_wdata` from the command registers. Next state is DONE.
- RD: `mem_read`=1, with `mem_addr` from the command register. Next state is RCAP.
- RCAP: `mem_rdata` is valid. `rdata` loads at the rising edge that leaves RCAP. Next state is DONE.
- DONE: `ack[owner]`=1. Next state is IDLE.
- Round-robin: the search starts at last_owner+1 and wraps modulo NREQ. last_owner updates only on a grant in IDLE.
- Reset values: state IDLE, last_owner=NREQ-1 (so requester 0 wins the first tie), and all outputs 0: ack, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata.
- All outputs are registered or decoded from state plus owner flops. There is no combinational path from `req` to any output.
- Boundary conditions:
  - `req` dropped mid-transaction: the transaction still completes from the latched command, and `ack` still pulses.
  - `req` still high in the IDLE cycle after `ack`: treated as a new transaction.
  - All requesters request together: granted in rotating order, one per transaction.
  - A requester that is not granted waits; it is starved for at most NREQ-1 transactions.
  - `rst` mid-operation: the FSM returns to IDLE immediately. `mem_write`/`mem_read` drop asynchronously, no `ack` is issued, and the command is lost.
  - Address wrap is not applicable; the address passes through unchanged.

## Timing
- Write: 3 cycles from IDLE-with-req to the end of DONE (IDLE, WR, DONE). `mem_write` is high for exactly 1 cycle.
- Read: 4 cycles (IDLE, RD, RCAP, DONE). `mem_read` is high for exactly 1 cycle, and `rdata` is valid in DONE.
- `mem_read` and `mem_write` are never high in the same cycle.
- `mem_addr`/`mem_wdata` hold their last value outside WR/RD.
- Back-to-back throughput, including the IDLE cycle: one write per 3 cycles, one read per 4 cycles.

## Structure
- Package mem_arb_pkg holds:
  - the state enum `arb_state_t` {IDLE, WR, RD, RCAP, DONE};
  - localparams for default AW=5, DW=8, NREQ=2.
- Sub-module rr_picker(NREQ) is combinational.
  - Inputs: `req` vector, last_owner.
  - Outputs: `found` and the winner index.
  - It is shared with future arbiters.
- The FSM, command registers and rdata register live in mem_arbiter.

## Test plan
- **Single write then read:** req0 writes addr 5 data 0x41, then reads addr 5.
  - `mem_write` is high for 1 cycle with addr=5 and wdata=0x41.
  - `ack[0]` pulses in cycle 3 of the write.
  - The read returns `rdata`=0x41 with `ack[0]` in cycle 4.
- **Simultaneous requests:** req0 writes addr 1 data 0x10 and req1 writes addr 2 data 0x20, both asserted at the same edge from reset.
  - req0 is granted first and req1 second.
  - Memory then holds 0x10 at addr 1 and 0x20 at addr 2.
- **Fairness:** both requesters hold `req` continuously for 6 transactions.
  - Grant order is 0,1,0,1,0,1.
  - No two consecutive `ack` pulses go to the same requester.
- **Address boundary:** write 0xFF to addr 31 and 0x00 to addr 0, then read both back.
  - Reads return 0xFF and 0x00.
  - `mem_addr` never exceeds 31.
- **Reset mid-read:** assert `rst` during RCAP.
  - `busy`, `mem_read` and `ack` are 0 in the same cycle, and `rdata`=0.
  - After `rst` is released, a read of addr 5 completes normally.
- **Request drop:** req1 issues a read and deasserts `req` during RD.
  - `ack[1]` still pulses in DONE.
  - The arbiter then returns to IDLE and stays there with `busy`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default sizes and index-width helper for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD, RCAP, DONE} arb_state_t;
  localparam int DEF_NREQ = 2;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 8;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester bundle (req/we/req_addr/req_wdata -> ack/rdata/busy) plus memory pin set.
// master = requesters and memory model side, slave = arbiter side.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0] ack;
  logic [DW-1:0] rdata;
  logic busy;
  logic mem_read;
  logic mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input req, we, req_addr, req_wdata, mem_rdata,
    output ack, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req, we, req_addr, req_wdata, mem_rdata,
    input ack, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting at last_i+1, wrapping modulo NREQ.
// Ports: req_i request vector, last_i previous owner, found_o any request, win_o winner index.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int OW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OW-1:0]   last_i,
  output logic            found_o,
  output logic [OW-1:0]   win_o
);
  int d;
  int best;
  // Each requester's distance past last_i; the smallest pending distance wins.
  always_comb begin
    found_o = |req_i;
    win_o = '0;
    best = NREQ;
    d = 0;
    for (int j = 0; j < NREQ; j++) begin
      d = (j + NREQ - 1 - int'(last_i)) % NREQ;
      if (req_i[j] && d < best) begin
        best = d;
        win_o = OW'(j);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sequencing one read or write per handshake onto a single-port memory.
// Ports: clk, rst (async active-high), bus (mem_arbiter_if.slave: requester handshake + memory pins).
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int OW = idx_w(NREQ);
  arb_state_t state_q;
  logic [OW-1:0] owner_q, last_q, win;
  logic found, busy_q, mem_read_q, mem_write_q;
  logic [NREQ-1:0] ack_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, rdata_q;
  rr_picker #(.NREQ(NREQ), .OW(OW)) u_pick (
    .req_i(bus.req),
    .last_i(last_q),
    .found_o(found),
    .win_o(win)
  );
  assign bus.ack = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy = busy_q;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // Outputs are set on the edge entering the state that presents them, so they stay registered.
  // mem_addr_q/mem_wdata_q double as the latched command and hold between transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= OW'(NREQ - 1);
      busy_q <= 1'b0;
      ack_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: if (found) begin
          state_q <= bus.we[win] ? WR : RD;
          owner_q <= win;
          last_q <= win;
          busy_q <= 1'b1;
          mem_addr_q <= bus.req_addr[win*AW +: AW];
          mem_write_q <= bus.we[win];
          mem_read_q <= !bus.we[win];
          if (bus.we[win]) mem_wdata_q <= bus.req_wdata[win*DW +: DW];
        end
        WR: begin
          state_q <= DONE;
          ack_q[owner_q] <= 1'b1;
        end
        RD: state_q <= RCAP;
        RCAP: begin
          state_q <= DONE;
          rdata_q <= bus.mem_rdata;
          ack_q[owner_q] <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a round-robin reference model and a behavioural 32x8 memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int NREQ = 3;
  localparam int AW = 5;
  localparam int DW = 8;
  typedef struct {
    int owner;
    bit we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  exp_t e;
  logic [DW-1:0] tb_mem[32];
  logic [DW-1:0] ref_mem[32];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int model_last = NREQ - 1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();
  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read) bus.mem_rdata <= tb_mem[bus.mem_addr];
  end
  always @(negedge clk) if (!rst) begin
    chk("strobe_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 0);
    if (bus.mem_read | bus.mem_write) begin
      if (q.size() == 0) chk("strobe_unexpected", 1, 0);
      else begin
        chk("strobe_kind", {31'd0, bus.mem_write}, {31'd0, q[0].we});
        chk("mem_addr", {27'd0, bus.mem_addr}, {27'd0, q[0].addr});
        if (q[0].we) chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, q[0].data});
        strobe_cyc = cyc;
      end
    end
    if (bus.ack != 0) begin
      if (q.size() == 0) chk("ack_unexpected", {29'd0, bus.ack}, 0);
      else begin
        e = q.pop_front();
        chk("ack_owner", {29'd0, bus.ack}, 32'd1 << e.owner);
        chk("ack_latency", cyc - strobe_cyc, e.we ? 1 : 2);
        chk("busy_in_done", {31'd0, bus.busy}, 1);
        if (!e.we) chk("rdata", {24'd0, bus.rdata}, {24'd0, e.data});
      end
    end
  end
  // Requesters drop req on their ack; a granted requester may also drop early after its strobe.
  always @(negedge clk) if (!rst) begin
    if ((bus.mem_read | bus.mem_write) && q.size() > 0 && $urandom_range(1) == 1)
      bus.req = bus.req & ~(NREQ'(1) << q[0].owner);
    bus.req = bus.req & ~bus.ack;
  end
  task automatic wait_idle();
    int t;
    for (t = 0; t < 100 && (q.size() != 0 || bus.req != 0); t++) @(negedge clk);
    chk("idle_timeout", {31'd0, q.size() != 0 || bus.req != 0}, 0);
    @(negedge clk);
  endtask
  // Model: all masked requesters are pending together; grant nearest after last owner, repeat.
  task automatic issue(input logic [NREQ-1:0] m, input logic [NREQ-1:0] w,
                       input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
    logic [NREQ-1:0] p;
    exp_t x;
    int c;
    wait_idle();
    p = m;
    while (p != 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (model_last + k) % NREQ;
        if (((p >> c) & 1) != 0) break;
      end
      p = p & ~(NREQ'(1) << c);
      model_last = c;
      x.owner = c;
      x.we = ((w >> c) & 1) != 0;
      x.addr = a[c*AW +: AW];
      if (x.we) begin
        x.data = d[c*DW +: DW];
        ref_mem[x.addr] = x.data;
      end else x.data = ref_mem[x.addr];
      q.push_back(x);
    end
    bus.we = w;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req = m;
    wait_idle();
  endtask
  initial begin
    int t;
    exp_t x;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.req = '0;
    bus.we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {29'd0, bus.ack}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_rdata", {24'd0, bus.rdata}, 0);
    chk("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 0);
    chk("rst_addr_wdata", {19'd0, bus.mem_addr, bus.mem_wdata}, 0);
    rst = 1'b0;
    issue(3'b001, 3'b001, {5'd0, 5'd0, 5'd5}, {8'h00, 8'h00, 8'h41});
    issue(3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, '0);
    issue(3'b011, 3'b011, {5'd0, 5'd2, 5'd1}, {8'h00, 8'h20, 8'h10});
    repeat (3) issue(3'b011, 3'b000, {5'd0, 5'd2, 5'd1}, '0);
    issue(3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, '0);
    issue(3'b001, 3'b001, {5'd0, 5'd0, 5'd31}, {8'h00, 8'h00, 8'hFF});
    issue(3'b010, 3'b010, {5'd0, 5'd0, 5'd0}, {8'h00, 8'h00, 8'h00});
    issue(3'b011, 3'b000, {5'd0, 5'd0, 5'd31}, '0);
    issue(3'b010, 3'b000, {5'd0, 5'd5, 5'd0}, '0);
    for (int n = 0; n < 80; n++)
      issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)), NREQ'($urandom),
            (NREQ*AW)'({$urandom, $urandom}), (NREQ*DW)'($urandom));
    wait_idle();
    x.owner = 0;
    x.we = 1'b0;
    x.addr = 5'd5;
    x.data = ref_mem[5];
    q.push_back(x);
    bus.we = '0;
    bus.req_addr = {5'd0, 5'd0, 5'd5};
    bus.req = 3'b001;
    for (t = 0; t < 20 && !bus.mem_read; t++) @(negedge clk);
    chk("rd_strobe_seen", {31'd0, bus.mem_read}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 0);
    chk("midrst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 0);
    chk("midrst_ack", {29'd0, bus.ack}, 0);
    chk("midrst_rdata", {24'd0, bus.rdata}, 0);
    q.delete();
    bus.req = '0;
    model_last = NREQ - 1;
    @(negedge clk);
    rst = 1'b0;
    issue(3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, '0);
    issue(3'b110, 3'b010, {5'd9, 5'd30, 5'd0}, {8'h00, 8'h5A, 8'h00});
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, bus.busy}, 0);
      chk("idle_ack", {29'd0, bus.ack}, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
